// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: controller states and decoded
// request operations.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_BAD   = 2'd2
    } op_t;

    // Exactly one of MemRead/MemWrite must be set for a well-formed request.
    function automatic op_t decode_op(input logic rd, input logic wr);
        case ({rd, wr})
            2'b10:   return OP_LOAD;
            2'b01:   return OP_STORE;
            default: return OP_BAD;
        endcase
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM with a registered read port; the read register
// captures the word at Addr on every rising edge.
module data_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  WrEn,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto RAM macros; the controller
    // zeroes it by walking every address after reset instead.
    always_ff @(posedge Clock) begin
        if (WrEn)
            mem[Addr] <= WrData;
        RdData <= mem[Addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the CPU data port: clears the RAM after reset, then
// serves one valid/ready request at a time with WAIT_STATES cycles of latency.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Error
);

    localparam int                DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit                NO_WAIT   = (WAIT_STATES == 0);

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [3:0]            wait_cnt;
    op_t                   op_in, op_q, commit_op;
    logic [ADDR_WIDTH-1:0] addr_q, ram_addr;
    logic [DATA_WIDTH-1:0] data_q, ram_wdata, ram_rdata;
    logic                  accept, last_wait, commit, ram_we;

    assign op_in = decode_op(MemRead, MemWrite);

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clock) begin
        if (Reset)
            state <= ST_CLEAR;
        else
            state <= state_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clr_cnt  <= '0;
            wait_cnt <= '0;
            op_q     <= OP_BAD;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + (ADDR_WIDTH+1)'(1);
            if (accept) begin
                op_q     <= op_in;
                addr_q   <= Address;
                data_q   <= WriteData;
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ReqReady   = 1'b0;
        RspValid   = 1'b0;
        accept     = 1'b0;
        last_wait  = 1'b0;
        case (state)
            ST_CLEAR: if (clr_cnt == CLR_LAST) state_next = ST_IDLE;
            ST_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    accept     = 1'b1;
                    state_next = NO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    last_wait  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                RspValid   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // With no wait states the op commits on the accept edge straight from the
    // request inputs; otherwise on the last WAIT edge from the latched copy.
    assign commit_op = NO_WAIT ? op_in : op_q;
    assign commit    = NO_WAIT ? accept : last_wait;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = data_q;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt[ADDR_WIDTH-1:0];
                ram_wdata = '0;
            end
            ST_IDLE: begin
                ram_addr  = Address;
                ram_wdata = WriteData;
            end
            default: ;
        endcase
        if (commit && commit_op == OP_STORE && !Reset)
            ram_we = 1'b1;
    end

    data_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .Clock  (Clock),
        .WrEn   (ram_we),
        .Addr   (ram_addr),
        .WrData (ram_wdata),
        .RdData (ram_rdata)
    );

    assign ReadData = (RspValid && op_q == OP_LOAD) ? ram_rdata : '0;
    assign Error    = RspValid && (op_q == OP_BAD);

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the CPU data-memory interface: accepts the datapath's load/store requests (MemRead/MemWrite plus address and write data) over a valid/ready handshake. It services them from an on-chip word-addressed RAM after a programmable number of wait states, then returns a one-cycle response. It sits between the CPU datapath and the data RAM and replaces the zero-latency combinational memory model. After reset it zeroes the whole array before accepting any traffic.

## Interface
- ADDR_WIDTH, 8, word-address width; array depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width in bits.
- WAIT_STATES, 1, cycles spent in WAIT per transaction; legal range 0..15.

- Clock  input  1  single system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  responder can accept a request this cycle.
- MemRead  input  1  request is a load; sampled on accept.
- MemWrite  input  1  request is a store; sampled on accept.
- Address  input  ADDR_WIDTH  word address; sampled on accept.
- WriteData  input  DATA_WIDTH  store data; sampled on accept.
- RspValid  output  1  one-cycle response pulse.
- ReadData  output  DATA_WIDTH  load result; valid while RspValid=1.
- Error  output  1  malformed request flag; valid while RspValid=1.

## Operation
- The controller has four states: CLEAR, IDLE, WAIT, RESP.
- **CLEAR**
  - Writes 0 to address ClrCnt each cycle and increments ClrCnt from 0.
  - After writing address 2**ADDR_WIDTH-1, moves to IDLE.
  - ReqReady=0 throughout.
- **IDLE**
  - ReqReady=1.
  - When ReqValid=1, the request is accepted: op, Address and WriteData are latched.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- **WAIT**
  - WaitCnt loads WAIT_STATES-1 on entry and decrements each cycle.
  - Moves to RESP when WaitCnt=0.
  - On the final WAIT cycle (or the accept edge when WAIT_STATES=0), the latched op is committed:
    - Store: RAM[addr] <= data.
    - Load: the read data register <= RAM[addr].
- **RESP**
  - RspValid=1 for exactly one cycle, then returns to IDLE.
  - There is no response backpressure; the requester must sample during RESP.
- **Op decode**
  - MemRead=1, MemWrite=0: load; ReadData = stored word.
  - MemRead=0, MemWrite=1: store; ReadData = 0.
  - Both high or both low: Error=1, ReadData=0, RAM unchanged.
- Error and ReadData are 0 in every cycle where RspValid=0.
- Reset values:
  - State = CLEAR, ClrCnt = 0, WaitCnt = 0.
  - ReqReady=0, RspValid=0, ReadData=0, Error=0.
- **Reset mid-operation**
  - Any in-flight transaction is dropped with no RspValid, including a store not yet committed.
  - The array is re-cleared from address 0.
  - Reset held high keeps the block in CLEAR with ClrCnt=0.
- Address arithmetic is unsigned. ClrCnt is ADDR_WIDTH+1 bits so the final-address check cannot wrap.

## Timing
- **Clear latency:** Reset deasserts at the end of cycle R. The block runs 2**ADDR_WIDTH CLEAR cycles, then ReqReady=1 in cycle R+1+2**ADDR_WIDTH.
- **Transaction timing** (request accepted in cycle 0):
  - Cycles 1..WAIT_STATES: WAIT.
  - Cycle WAIT_STATES+1: RESP, RspValid=1.
  - Cycle WAIT_STATES+2: IDLE, ReqReady=1.
- **Throughput:** one transaction per WAIT_STATES+2 cycles. With WAIT_STATES=0: accept in cycle 0, response in cycle 1, ready again in cycle 2.
- **Read-after-write:** a load to an address accepted after a store's RspValid returns the stored value.
- ReqValid while ReqReady=0 is ignored; the requester holds the request until accepted.
- Inputs are sampled only on the accept edge; changes afterwards do not affect the transaction.
- ReqReady and RspValid are never high in the same cycle.

## Structure
- **Shared package dm_pkg**, holding:
  - State encoding constants ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP (2-bit).
  - Op constants OP_LOAD, OP_STORE, OP_BAD (2-bit).
- **Sub-module data_ram:** single-port synchronous RAM.
  - Ports: Clock, WrEn, Addr, WrData, RdData; no reset.
  - The top-level muxes Addr/WrData between the clear counter and the latched request.
- The FSM, counters and response registers live in data_mem_responder.

## Test plan
- **Reset clear:** with defaults, store 16'hBEEF at 8'h10, pulse Reset, wait for ReqReady, load 8'h10 -> ReadData=16'h0000, Error=0.
- **Store then load:** with WAIT_STATES=1, store 16'h1234 at 8'h05, then load 8'h05.
  - Each RspValid arrives exactly 2 cycles after accept.
  - The load returns 16'h1234.
- **Zero wait:** with WAIT_STATES=0, store 16'hA5A5 at 8'hFF, then load 8'hFF -> RspValid 1 cycle after accept, ReadData=16'hA5A5; ReqReady returns in the following cycle.
- **Malformed op:** MemRead=MemWrite=1 at 8'h05 holding 16'h1234 -> RspValid with Error=1, ReadData=0; a subsequent load of 8'h05 returns 16'h1234.
- **Reset during WAIT:** with WAIT_STATES=4, store 16'h7777 at 8'h20 and assert Reset in WAIT cycle 2 -> no RspValid, ReqReady=0 until clear completes, then load 8'h20 returns 16'h0000.
- **Handshake stall:** hold ReqValid=1 during CLEAR and RESP -> no accept until ReqReady=1; exactly one transaction is accepted per request.
